// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the memory interface unit.
//   mem_state_e   - transaction state (idle / read in flight / write in flight)
//   *Def          - default parameter values for mem_unit
package mem_pkg;

  localparam int unsigned WordSizeDef = 32;
  localparam int unsigned AddrSizeDef = 32;
  localparam int unsigned TimeoutDef  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_timer.sv
// mem_timer: wait-state counter used to abort memory accesses that never complete.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset
//   clear_i    - synchronous clear of the count (has priority over enable_i)
//   enable_i   - count this cycle
//   expired_o  - high when an enabled cycle brings the count up to Limit
module mem_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Flags the cycle whose increment would make the count equal Limit, so the
  // owner can leave its wait state on that same edge.
  assign expired_o = enable_i && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: memory interface unit with latched address/data (MAR/MDR), a
// multi-cycle ready handshake towards memory and a tri-state CPU result bus.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT wait
// cycles and pulse err; without it err is tied low and accesses wait forever).
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start_rd, start_wr   - request read / write (sampled only while idle)
//   addr_in, data_in     - address and write data, sampled with the start
//   oe, out              - out drives MDR when oe, else high-Z
//   busy, done, err      - in-progress flag, completion pulse, timeout pulse
//   mem_addr, mem_wdata  - latched address and write data towards memory
//   mem_rdata            - read data from memory
//   mem_rd, mem_wr       - access strobes, held until mem_ready
//   mem_ready            - memory completes the current access this cycle
module mem_unit
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WordSizeDef,
  parameter int unsigned ADDR_SIZE = AddrSizeDef,
  parameter int unsigned TIMEOUT   = TimeoutDef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_rd,
  input  logic                 start_wr,
  input  logic [WORD_SIZE-1:0] addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 oe,
  output tri   [WORD_SIZE-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic                 mem_ready
);

  mem_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] mdr_q, mdr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 expired;

`ifdef MEM_TIMEOUT_EN
  // Count is held at zero while idle, so it starts fresh for each access.
  mem_timer #(
    .Limit(TIMEOUT)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (state_q == StIdle),
    .enable_i ((state_q != StIdle) && !mem_ready),
    .expired_o(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Read wins when both starts arrive together; the write is dropped.
        if (start_rd || start_wr) begin
          state_d = start_rd ? StRead : StWrite;
          addr_d  = addr_in[ADDR_SIZE-1:0];
          wdata_d = data_in;
        end
      end
      StRead, StWrite: begin
        // mem_ready beats a timeout expiring in the same cycle.
        if (mem_ready) begin
          mdr_d   = (state_q == StRead) ? mem_rdata : wdata_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Strobes are decodes of the state register, so they drop as soon as
  // reset clears it.
  assign busy      = (state_q != StIdle);
  assign mem_rd    = (state_q == StRead);
  assign mem_wr    = (state_q == StWrite);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign out       = oe ? mdr_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed and randomized bench for mem_unit, with a
// transaction-level reference model compared on every falling clock edge.
module tb_mem_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_rd = 1'b0, start_wr = 1'b0, oe = 1'b0, mem_ready = 1'b0;
  logic [31:0] addr_in = '0, data_in = '0, mem_rdata = '0;
  wire  [31:0] out;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;

  mem_unit #(
    .WORD_SIZE(32),
    .ADDR_SIZE(32),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_rd (start_rd),
    .start_wr (start_wr),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .oe       (oe),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = no access, 1 = read pending, 2 = write pending.
  int          m_kind  = 0;
  int          m_waits = 0;
  logic [31:0] m_addr  = '0, m_wdata = '0, m_mdr = '0;
  bit          m_done  = 1'b0, m_err = 1'b0;
`ifdef MEM_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kind <= 0; m_waits <= 0; m_addr <= '0; m_wdata <= '0; m_mdr <= '0;
      m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (m_kind == 0) begin
        if (start_rd || start_wr) begin
          m_kind  <= start_rd ? 1 : 2;
          m_addr  <= addr_in;
          m_wdata <= data_in;
          m_waits <= 0;
        end
      end else if (mem_ready) begin
        m_mdr  <= (m_kind == 1) ? mem_rdata : m_wdata;
        m_done <= 1'b1;
        m_kind <= 0;
      end else begin
        m_waits <= m_waits + 1;
        if (TimeoutOn && (m_waits + 1 == int'(TO))) begin
          m_err  <= 1'b1;
          m_kind <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_kind != 0));
      chk("mem_rd", 32'(mem_rd), 32'(m_kind == 1));
      chk("mem_wr", 32'(mem_wr), 32'(m_kind == 2));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      if (oe) chk("out", out, m_mdr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int wr_cnt, busy_cnt, done_cnt;

  initial begin
    #3 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Zero-wait read
    start_rd = 1'b1; addr_in = 32'h100;
    step();
    start_rd = 1'b0;
    chk("zw_addr", mem_addr, 32'h100);
    chk("zw_rd", 32'(mem_rd), 32'd1);
    chk("zw_done_early", 32'(done), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ready = 1'b0;
    chk("zw_done", 32'(done), 32'd1);
    chk("zw_idle", 32'(busy), 32'd0);
    oe = 1'b1; #1;
    chk("zw_out", out, 32'hDEADBEEF);
    oe = 1'b0;
    step();

    // Write with three wait states
    start_wr = 1'b1; addr_in = 32'h200; data_in = 32'h12345678;
    step();
    start_wr = 1'b0; data_in = 32'h0;
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int j = 1; j <= 4; j++) begin
      wr_cnt += int'(mem_wr); busy_cnt += int'(busy); done_cnt += int'(done);
      mem_ready = (j == 4);
      step();
    end
    mem_ready = 1'b0;
    wr_cnt += int'(mem_wr); busy_cnt += int'(busy); done_cnt += int'(done);
    step();
    done_cnt += int'(done);
    chk("ws_wr_cycles", 32'(wr_cnt), 32'd4);
    chk("ws_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("ws_done_count", 32'(done_cnt), 32'd1);
    oe = 1'b1; #1;
    chk("ws_out", out, 32'h12345678);
    oe = 1'b0;

    // Simultaneous starts, then a write request during the read
    start_rd = 1'b1; start_wr = 1'b1; addr_in = 32'h300;
    step();
    start_rd = 1'b0; addr_in = 32'h999;
    chk("sim_rd", 32'(mem_rd), 32'd1);
    chk("sim_wr", 32'(mem_wr), 32'd0);
    step();
    chk("busy_wr_ignored", 32'(mem_wr), 32'd0);
    chk("busy_addr_held", mem_addr, 32'h300);
    start_wr = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ready = 1'b0;
    chk("sim_done", 32'(done), 32'd1);
    step();
    chk("no_queue", 32'(busy), 32'd0);

    // Back-to-back reads
    start_rd = 1'b1; addr_in = 32'h400;
    step();
    start_rd = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    step();
    chk("b2b_done1", 32'(done), 32'd1);
    start_rd = 1'b1; addr_in = 32'h404; mem_ready = 1'b0;
    step();
    start_rd = 1'b0;
    chk("b2b_rd2", 32'(mem_rd), 32'd1);
    chk("b2b_addr2", mem_addr, 32'h404);
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_ready = 1'b0;
    chk("b2b_done2", 32'(done), 32'd1);
    oe = 1'b1; #1;
    chk("b2b_out", out, 32'h22222222);
    oe = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Timeout abort, then completion on the expiry cycle
    start_rd = 1'b1; addr_in = 32'h500;
    step();
    start_rd = 1'b0;
    for (int j = 1; j <= int'(TO); j++) step();
    chk("to_err", 32'(err), 32'd1);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    oe = 1'b1; #1;
    chk("to_mdr_kept", out, 32'h22222222);
    oe = 1'b0;
    step();
    chk("to_err_pulse", 32'(err), 32'd0);
    start_rd = 1'b1; addr_in = 32'h600;
    step();
    start_rd = 1'b0;
    for (int j = 1; j < int'(TO); j++) step();
    mem_ready = 1'b1; mem_rdata = 32'h33333333;
    step();
    mem_ready = 1'b0;
    chk("exp_done", 32'(done), 32'd1);
    chk("exp_no_err", 32'(err), 32'd0);
`endif

    // Reset in the second wait cycle of a read
    start_rd = 1'b1; addr_in = 32'h700;
    step();
    start_rd = 1'b0;
    step();
    rst = 1'b1; #1;
    chk("mr_rd", 32'(mem_rd), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_addr", mem_addr, 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    oe = 1'b1; #1;
    chk("mr_out", out, 32'd0);
    oe = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("mr_no_done", 32'(done), 32'd0);
    chk("mr_no_err", 32'(err), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start_rd  = ($urandom_range(0, 3) == 0);
      start_wr  = ($urandom_range(0, 2) == 0);
      addr_in   = $urandom;
      data_in   = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 3) == 0);
      oe        = $urandom_range(0, 1) == 1;
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; start_rd = 1'b0; start_wr = 1'b0; mem_ready = 1'b0; oe = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
